// File: rtl/serdes_pkg.sv
// Shared 8b/10b serdes constants and transmit FSM states.
package serdes_pkg;

    localparam int WORD_W = 10;

    localparam logic [WORD_W-1:0] K28_5_RDN = 10'd380;
    localparam logic [WORD_W-1:0] K28_5_RDP = 10'd643;

    typedef enum logic {
        ALIGN = 1'b0,
        DATA  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/tx_piso.sv
// 10-bit parallel-in serial-out transmitter, LSB first,
// with a comma alignment preamble after reset and comma fill when idle.
module tx_piso
    import serdes_pkg::*;
#(
    parameter int ALIGN_WORDS = 4
) (
    input  logic              BitCLK,
    input  logic              Reset,
    input  logic [WORD_W-1:0] TxParallel_10,
    input  logic              TxValid,
    output logic              TxReady,
    output logic              Serial,
    output logic              TxIdle
);

    tx_state_e         state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        align_cnt_q, align_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              rdp_q, rdp_d;
    logic              idle_q, idle_d;
    logic              load;
    logic [WORD_W-1:0] comma;

    assign load  = (bit_cnt_q == 4'd9);
    assign comma = rdp_q ? K28_5_RDP : K28_5_RDN;

    assign TxReady = (state_q == DATA) && load;
    assign Serial  = shift_q[0];
    assign TxIdle  = idle_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = load ? 4'd0 : bit_cnt_q + 4'd1;
        align_cnt_d = align_cnt_q;
        shift_d     = {1'b0, shift_q[WORD_W-1:1]};
        rdp_d       = rdp_q;
        idle_d      = idle_q;
        if (load) begin
            if (TxReady && TxValid) begin
                shift_d = TxParallel_10;
                idle_d  = 1'b0;
            end else begin
                shift_d = comma;
                rdp_d   = ~rdp_q;
                idle_d  = 1'b1;
            end
            if (state_q == ALIGN) begin
                align_cnt_d = align_cnt_q + 4'd1;
                if (align_cnt_q == 4'(ALIGN_WORDS - 1)) begin
                    state_d = DATA;
                end
            end
        end
    end

    always_ff @(posedge BitCLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ALIGN;
            bit_cnt_q   <= 4'd9;
            align_cnt_q <= 4'd0;
            shift_q     <= '0;
            rdp_q       <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            align_cnt_q <= align_cnt_d;
            shift_q     <= shift_d;
            rdp_q       <= rdp_d;
            idle_q      <= idle_d;
        end
    end

endmodule

// File: tb/tb_tx_piso.sv
// Directed checks of tx_piso framing, handshake, comma fill and reset.
module tb_tx_piso;

    logic       clk;
    logic       rst_n;
    logic [9:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ser;
    logic       tx_idle;

    int n_chk;
    int n_fail;
    bit exp_rdp;

    tx_piso #(.ALIGN_WORDS(4)) dut (
        .BitCLK       (clk),
        .Reset        (rst_n),
        .TxParallel_10(tx_data),
        .TxValid      (tx_valid),
        .TxReady      (tx_ready),
        .Serial       (ser),
        .TxIdle       (tx_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] next_comma();
        logic [9:0] c;
        c = exp_rdp ? 10'd643 : 10'd380;
        exp_rdp = ~exp_rdp;
        return c;
    endfunction

    // Entered at a negedge just before a load edge; leaves at the same phase.
    task automatic xfer(input logic v, input logic [9:0] d, input bit pulse,
                        output logic [9:0] w, output logic rdy,
                        output logic idle);
        rdy = tx_ready;
        tx_valid = v;
        tx_data = d;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) tx_valid = 1'b0;
            if (pulse && i == 4) tx_valid = 1'b1;
            if (pulse && i == 5) tx_valid = 1'b0;
            w[i] = ser;
            idle = tx_idle;
        end
    endtask

    task automatic chk_word(input string nm, input logic [9:0] w,
                            input logic rdy, input logic idle,
                            input logic [9:0] ew, input logic erdy,
                            input logic eidle);
        n_chk++;
        if (w !== ew || rdy !== erdy || idle !== eidle) begin
            n_fail++;
            $display("FAIL %s: got word=%h rdy=%b idle=%b, want word=%h rdy=%b idle=%b",
                     nm, w, rdy, idle, ew, erdy, eidle);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        exp_rdp = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (ser !== 1'b0 || tx_ready !== 1'b0 || tx_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got ser=%b rdy=%b idle=%b, want 0 0 0",
                     ser, tx_ready, tx_idle);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_align();
        logic [9:0] w;
        logic r, id;
        for (int k = 0; k < 4; k++) begin
            xfer(1'b1, 10'h2AA, 1'b0, w, r, id);
            chk_word($sformatf("align%0d", k), w, r, id, next_comma(), 1'b0, 1'b1);
        end
    endtask

    task automatic test_data();
        logic [9:0] w;
        logic r, id;
        xfer(1'b1, 10'h2AA, 1'b0, w, r, id);
        chk_word("data_2AA", w, r, id, 10'h2AA, 1'b1, 1'b0);
        xfer(1'b1, 10'h155, 1'b0, w, r, id);
        chk_word("data_155", w, r, id, 10'h155, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_mid();
        logic [9:0] w;
        logic r, id;
        xfer(1'b0, 10'h0F0, 1'b1, w, r, id);
        chk_word("idle_fill", w, r, id, next_comma(), 1'b1, 1'b1);
        xfer(1'b0, 10'h0F0, 1'b0, w, r, id);
        chk_word("mid_pulse_ignored", w, r, id, next_comma(), 1'b1, 1'b1);
    endtask

    task automatic test_alternation();
        logic [9:0] w;
        logic r, id;
        xfer(1'b1, 10'h3C1, 1'b0, w, r, id);
        chk_word("data_3C1", w, r, id, 10'h3C1, 1'b1, 1'b0);
        xfer(1'b0, 10'h000, 1'b0, w, r, id);
        chk_word("alt_a", w, r, id, next_comma(), 1'b1, 1'b1);
        xfer(1'b0, 10'h000, 1'b0, w, r, id);
        chk_word("alt_b", w, r, id, next_comma(), 1'b1, 1'b1);
    endtask

    task automatic test_loopback();
        logic [9:0] rx;
        logic [9:0] sent [3];
        logic [9:0] got [3];
        int nbits;
        int align_at;
        sent[0] = next_comma();
        sent[1] = 10'h2AA;
        sent[2] = 10'h155;
        rx = '0;
        nbits = 0;
        align_at = -1;
        for (int k = 0; k < 3; k++) begin
            tx_valid = (k != 0);
            tx_data = sent[k];
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (i == 0) tx_valid = 1'b0;
                rx = {ser, rx[9:1]};
                nbits++;
                if (align_at < 0 && (rx == 10'd380 || rx == 10'd643))
                    align_at = nbits;
                if (align_at > 0 && (nbits - align_at) % 10 == 0)
                    got[(nbits - align_at) / 10] = rx;
            end
        end
        n_chk++;
        if (align_at != 10) begin
            n_fail++;
            $display("FAIL loop_align: got bit %0d, want 10", align_at);
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (align_at != 10 || got[k] !== sent[k]) begin
                n_fail++;
                $display("FAIL loop_word%0d: got %h, want %h", k, got[k], sent[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] w;
        logic r, id;
        r = tx_ready;
        tx_valid = 1'b1;
        tx_data = 10'h3FF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b0;
        end
        n_chk++;
        if (ser !== 1'b1 || r !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got ser=%b rdy=%b, want 1 1", ser, r);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ser !== 1'b0 || tx_ready !== 1'b0 || tx_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got ser=%b rdy=%b idle=%b, want 0 0 0",
                     ser, tx_ready, tx_idle);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_rdp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            xfer(1'b1, 10'h2AA, 1'b0, w, r, id);
            chk_word($sformatf("realign%0d", k), w, r, id, next_comma(), 1'b0, 1'b1);
        end
        xfer(1'b1, 10'h1E3, 1'b0, w, r, id);
        chk_word("post_reset_data", w, r, id, 10'h1E3, 1'b1, 1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_align();
        test_data();
        test_ignore_mid();
        test_alternation();
        test_loopback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
